// File: rtl/pe_pkg.sv
// Shared definitions for the systolic-array PE: lane widths, mode codes, saturating add.
// Optional feature macro: PE_SAT_EN (saturating accumulate/drain instead of wrap).
package pe_pkg;

  localparam int LANES = 4;
  localparam int A_W   = 16;
  localparam int B_W   = 8;
  localparam int C_W   = 32;
  localparam int P_W   = A_W + B_W;
  localparam int IDX_W = $clog2(LANES);

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_DENDEN = 2'b00;
  localparam mode_t MODE_SPADEN = 2'b01;
  localparam mode_t MODE_SHIFT  = 2'b10;
  localparam mode_t MODE_DRAIN  = 2'b11;

  localparam logic [C_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [C_W-1:0] SAT_MIN = 32'h8000_0000;

  // Signed add clamped to the 32-bit range; overflow only when both operands share a sign
  // and the result does not.
  function automatic logic [C_W-1:0] sat32(input logic [C_W-1:0] x, input logic [C_W-1:0] y);
    logic [C_W-1:0] s;
    s = x + y;
    if ((x[C_W-1] == y[C_W-1]) && (s[C_W-1] != x[C_W-1]))
      s = x[C_W-1] ? SAT_MIN : SAT_MAX;
    return s;
  endfunction

endpackage

// File: rtl/pe_dot4.sv
// Combinational mask gather plus 4-lane signed dot product, sign-extended to C_W.
// Dense mode uses every lane in place; sparse mode pairs packed A[k] with the k-th set mask bit.
module pe_dot4
  import pe_pkg::*;
(
  input  logic                   sparse,
  input  logic [LANES-1:0]       mask,
  input  logic [LANES*A_W-1:0]   a,
  input  logic [LANES*B_W-1:0]   b,
  output logic [C_W-1:0]         sum
);

  logic [P_W-1:0] prod [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [IDX_W-1:0]      idx;
      logic signed [A_W-1:0] a_sel;
      logic signed [B_W-1:0] b_lane;
      logic signed [P_W-1:0] p;
      logic                  lane_on;

      // Packed A index for this B lane = number of set mask bits below it.
      always_comb begin
        idx = '0;
        for (int j = 0; j < gi; j++)
          idx = idx + IDX_W'(mask[j]);
      end

      assign a_sel   = sparse ? a[idx*A_W +: A_W] : a[gi*A_W +: A_W];
      assign b_lane  = b[gi*B_W +: B_W];
      assign lane_on = sparse ? mask[gi] : 1'b1;
      assign p       = a_sel * b_lane;
      assign prod[gi] = lane_on ? p : '0;
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++)
      sum = sum + {{(C_W-P_W){prod[i][P_W-1]}}, prod[i]};
  end

endmodule

// File: rtl/pe.sv
// Systolic-array PE: forwards A/mask east and B south, accumulates dense or sparse dot products,
// and passes or drains C down the cin->cOut chain. Define PE_SAT_EN for saturating adds.
module pe
  import pe_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic [LANES-1:0]     maskin,
  input  logic [LANES*A_W-1:0] ain,
  input  logic [LANES*B_W-1:0] bin,
  input  logic [C_W-1:0]       cin,
  input  logic [1:0]           mode,
  output logic [LANES-1:0]     maskOut,
  output logic [LANES*A_W-1:0] aOut,
  output logic [LANES*B_W-1:0] bOut,
  output logic [C_W-1:0]       cOut
);

  logic [C_W-1:0] acc_reg;
  logic [C_W-1:0] acc_next;
  logic [C_W-1:0] cout_next;
  logic [C_W-1:0] dot_sum;
  logic [C_W-1:0] acc_sum;
  logic [C_W-1:0] drain_sum;

  pe_dot4 u_dot (
    .sparse (mode == MODE_SPADEN),
    .mask   (maskin),
    .a      (ain),
    .b      (bin),
    .sum    (dot_sum)
  );

`ifdef PE_SAT_EN
  assign acc_sum   = sat32(acc_reg, dot_sum);
  assign drain_sum = sat32(acc_reg, cin);
`else
  assign acc_sum   = acc_reg + dot_sum;
  assign drain_sum = acc_reg + cin;
`endif

  always_comb begin
    acc_next  = acc_reg;
    cout_next = cOut;
    case (mode)
      MODE_DENDEN,
      MODE_SPADEN: acc_next = acc_sum;
      MODE_SHIFT:  cout_next = cin;
      MODE_DRAIN: begin
        cout_next = drain_sum;
        acc_next  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      maskOut <= '0;
      aOut    <= '0;
      bOut    <= '0;
      cOut    <= '0;
      acc_reg <= '0;
    end else if (en) begin
      maskOut <= maskin;
      aOut    <= ain;
      bOut    <= bin;
      cOut    <= cout_next;
      acc_reg <= acc_next;
    end
  end

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: directed vector table, reset/overflow sequences, and a
// randomized run against a list-based reference model. Honours PE_SAT_EN when defined.
module tb_pe;

  logic        clock;
  logic        reset;
  logic        en;
  logic [3:0]  maskin;
  logic [63:0] ain;
  logic [31:0] bin;
  logic [31:0] cin;
  logic [1:0]  mode;
  logic [3:0]  maskOut;
  logic [63:0] aOut;
  logic [31:0] bOut;
  logic [31:0] cOut;

  int total = 0;
  int bad   = 0;

  pe dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .maskin  (maskin),
    .ain     (ain),
    .bin     (bin),
    .cin     (cin),
    .mode    (mode),
    .maskOut (maskOut),
    .aOut    (aOut),
    .bOut    (bOut),
    .cOut    (cOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  mask;
    logic [63:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp_c;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t tbl[$];

  localparam longint MAXV = 64'sh7FFF_FFFF;
  localparam longint MINV = -64'sh8000_0000;

  // Reference model state
  longint      m_acc;
  logic [31:0] m_c;
  logic [3:0]  m_mask;
  logic [63:0] m_a;
  logic [31:0] m_b;

  function automatic longint fold(longint x);
`ifdef PE_SAT_EN
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
`else
    return longint'(int'(x));
`endif
  endfunction

  // Lanes taking part, in order; the k-th one multiplies packed A element k.
  function automatic longint ref_dot(bit sparse, logic [3:0] m, logic [63:0] a, logic [31:0] b);
    int     pos[$];
    longint s = 0;
    logic [15:0] ae;
    logic [7:0]  be;
    for (int i = 0; i < 4; i++)
      if (!sparse || m[i]) pos.push_back(i);
    for (int k = 0; k < pos.size(); k++) begin
      ae = a[16*k +: 16];
      be = b[8*pos[k] +: 8];
      s += longint'(shortint'(ae)) * longint'(byte'(be));
    end
    return s;
  endfunction

  task automatic model_step(logic e, logic [1:0] md, logic [3:0] m, logic [63:0] a,
                            logic [31:0] b, logic [31:0] c);
    if (e) begin
      case (md)
        2'b00: m_acc = fold(m_acc + ref_dot(1'b0, m, a, b));
        2'b01: m_acc = fold(m_acc + ref_dot(1'b1, m, a, b));
        2'b10: m_c = c;
        default: begin
          m_c   = 32'(fold(m_acc + longint'(int'(c))));
          m_acc = 0;
        end
      endcase
      m_mask = m;
      m_a    = a;
      m_b    = b;
    end
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(string name, logic e, logic [1:0] md, logic [3:0] m, logic [63:0] a,
                      logic [31:0] b, logic [31:0] c);
    en = e; mode = md; maskin = m; ain = a; bin = b; cin = c;
    @(posedge clock);
    #1;
    $display("%s: en=%0b mode=%0d mask=%h cin=%h -> cOut=%h maskOut=%h", name, e, md, m, c, cOut, maskOut);
  endtask

  task automatic add_vec(string n, logic e, logic [1:0] md, logic [3:0] m, logic [63:0] a,
                         logic [31:0] b, logic [31:0] c, logic [31:0] ec, logic [3:0] em);
    vec_t v;
    v.name = n; v.en = e; v.mode = md; v.mask = m; v.a = a; v.b = b; v.c = c;
    v.exp_c = ec; v.exp_mask = em;
    tbl.push_back(v);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    m_acc = 0; m_c = '0; m_mask = '0; m_a = '0; m_b = '0;
  endtask

  logic [63:0] ea;
  logic [31:0] eb;

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; maskin = '0; ain = '0; bin = '0; cin = '0;

    add_vec("dense",     1, 2'b00, 4'h0, 64'h0004_0003_0002_0001, 32'h0403_0201, 32'h0, 32'h0,  4'h0);
    add_vec("drain_c5",  1, 2'b11, 4'h0, 64'h0,                   32'h0,         32'h5, 32'h23, 4'h0);
    add_vec("drain_0",   1, 2'b11, 4'h0, 64'h0,                   32'h0,         32'h0, 32'h0,  4'h0);
    add_vec("sparse",    1, 2'b01, 4'hA, 64'h0000_0000_0003_0002, 32'h0A14_1E28, 32'h0, 32'h0,  4'hA);
    add_vec("sp_drain",  1, 2'b11, 4'h0, 64'h0,                   32'h0,         32'h0, 32'h5A, 4'h0);
    add_vec("signed",    1, 2'b00, 4'h0, 64'h0000_0000_0000_FFFF, 32'h0000_0080, 32'h0, 32'h5A, 4'h0);
    add_vec("sg_drain",  1, 2'b11, 4'h0, 64'h0,                   32'h0,         32'h0, 32'h80, 4'h0);
    add_vec("acc21",     1, 2'b00, 4'h3, 64'h0000_0000_0000_0007, 32'h0000_0003, 32'h0, 32'h80, 4'h3);
    add_vec("shift",     1, 2'b10, 4'h0, 64'h0,                   32'h0,  32'h0000_9999, 32'h9999, 4'h0);
    add_vec("sh_drain",  1, 2'b11, 4'h0, 64'h0,                   32'h0,         32'h0, 32'h15, 4'h0);
    add_vec("hold_a",    0, 2'b00, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'h15, 4'h0);
    add_vec("hold_b",    0, 2'b11, 4'h5, 64'h1234_5678_9ABC_DEF0, 32'h8765_4321, 32'h77,   32'h15, 4'h0);
    add_vec("mask0",     1, 2'b01, 4'h0, 64'h1111_1111_1111_1111, 32'h7F7F_7F7F, 32'h0, 32'h15, 4'h0);
    add_vec("m0_drain",  1, 2'b11, 4'h0, 64'h0,                   32'h0,         32'h1, 32'h1,  4'h0);
    add_vec("sp_lane2",  1, 2'b01, 4'h4, 64'h7777_7777_7777_FFFE, 32'h7F05_7F7F, 32'h0, 32'h1,  4'h4);
    add_vec("dense_b2b", 1, 2'b00, 4'h0, 64'h0000_0000_0002_0000, 32'h0000_0300, 32'h0, 32'h1,  4'h0);
    add_vec("neg_drain", 1, 2'b11, 4'h0, 64'h0,                   32'h0,         32'h0, 32'hFFFF_FFFC, 4'h0);

    // Reset state, sampled while reset is still held
    #12;
    check("rst_cout", 64'(cOut), 64'h0);
    check("rst_mask", 64'(maskOut), 64'h0);
    check("rst_aout", aOut, 64'h0);
    check("rst_bout", 64'(bOut), 64'h0);
    reset = 1'b0;

    ea = '0; eb = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].name, tbl[i].en, tbl[i].mode, tbl[i].mask, tbl[i].a, tbl[i].b, tbl[i].c);
      if (tbl[i].en) begin
        ea = tbl[i].a;
        eb = tbl[i].b;
      end
      check({tbl[i].name, "_cout"}, 64'(cOut), 64'(tbl[i].exp_c));
      check({tbl[i].name, "_mask"}, 64'(maskOut), 64'(tbl[i].exp_mask));
      check({tbl[i].name, "_aout"}, aOut, ea);
      check({tbl[i].name, "_bout"}, 64'(bOut), 64'(eb));
    end

    // Reset between edges mid-accumulation: outputs clear at once and acc is discarded
    step("pre_rst_acc", 1, 2'b00, 4'h0, 64'h0001_0001_0001_0001, 32'h0101_0101, 32'h0);
    step("pre_rst_shift", 1, 2'b10, 4'hF, 64'h0001_0001_0001_0001, 32'h0101_0101, 32'hABCD);
    check("pre_rst_cout", 64'(cOut), 64'hABCD);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_cout", 64'(cOut), 64'h0);
    check("mid_rst_mask", 64'(maskOut), 64'h0);
    check("mid_rst_aout", aOut, 64'h0);
    check("mid_rst_bout", 64'(bOut), 64'h0);
    reset = 1'b0;
    step("post_rst_drain", 1, 2'b11, 4'h0, 64'h0, 32'h0, 32'h0);
    check("post_rst_drain", 64'(cOut), 64'h0);

    // Overflow: 127 x 0x01000000 then 0x00FFFF00 brings acc to 0x7FFFFF00, then +512
    pulse_reset();
    for (int i = 0; i < 127; i++)
      step("preload", 1, 2'b00, 4'h0, 64'h8000_8000_8000_8000, 32'h8080_8080, 32'h0);
    step("preload_tail", 1, 2'b00, 4'h0, 64'h8002_8000_8000_8000, 32'h8080_8080, 32'h0);
    step("ovf_add", 1, 2'b00, 4'h0, 64'h0000_0000_0000_0200, 32'h0000_0001, 32'h0);
    step("ovf_drain", 1, 2'b11, 4'h0, 64'h0, 32'h0, 32'h0);
`ifdef PE_SAT_EN
    check("ovf_drain", 64'(cOut), 64'h7FFF_FFFF);
`else
    check("ovf_drain", 64'(cOut), 64'h8000_0100);
`endif

    // Randomized run against the reference model
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      logic        r_en;
      logic [1:0]  r_mode;
      logic [3:0]  r_mask;
      logic [63:0] r_a;
      logic [31:0] r_b;
      logic [31:0] r_c;
      r_en   = ($urandom_range(0, 7) != 0);
      r_mode = 2'($urandom_range(0, 3));
      r_mask = 4'($urandom);
      r_a    = {$urandom, $urandom};
      r_b    = $urandom;
      r_c    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
      model_step(r_en, r_mode, r_mask, r_a, r_b, r_c);
      step($sformatf("rand%0d", i), r_en, r_mode, r_mask, r_a, r_b, r_c);
      check("rand_cout", 64'(cOut), 64'(m_c));
      check("rand_mask", 64'(maskOut), 64'(m_mask));
      check("rand_aout", aOut, m_a);
      check("rand_bout", 64'(bOut), 64'(m_b));
    end
    step("rand_final_drain", 1, 2'b11, 4'h0, 64'h0, 32'h0, 32'h0);
    model_step(1'b1, 2'b11, 4'h0, 64'h0, 32'h0, 32'h0);
    check("rand_final_drain", 64'(cOut), 64'(m_c));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
